// File: rtl/round_add_ctrl.sv
// round_add_ctrl
//   Rounding-stage sequencer for the multiplier datapath. It takes a normalised
//   mantissa with exponent, sign and guard/round/sticky bits, and decides whether
//   the mantissa must be incremented. For an increment it drives an external
//   registered SW-bit round adder, which has a one-cycle load latency. It then
//   checks the adder carry and renormalises on mantissa overflow. The rounded
//   mantissa and exponent are returned together with a one-cycle done pulse.
//
//   Optional feature macro: ROUND_MODES_EN
//     defined   : rmode_i selects RNE / RTZ / toward +inf / toward -inf
//     undefined : rmode_i is ignored and round-to-nearest-even is always used
//
//   Parameters
//     SW : mantissa / round adder width (must match the adder instance)
//     EW : exponent width
//
//   Ports
//     clk, rst              : clock (rising edge), async active-low reset
//     start_i / ready_o     : request handshake; start_i only taken while ready_o
//     mant_i, exp_i, sign_i : operand to round
//     guard_i/round_i/sticky_i : bits below the mantissa LSB
//     rmode_i               : 00 RNE, 01 RTZ, 10 +inf, 11 -inf
//     add_a_o/add_b_o/add_load_o : operands and load strobe to the round adder
//     add_sum_i/add_carry_i : registered adder result
//     mant_o, exp_o, ovf_o, inexact_o : rounded result and flags
//     done_o                : one-cycle pulse, results valid
module round_add_ctrl #(
  parameter int SW = 26,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          ready_o,
  input  logic [SW-1:0] mant_i,
  input  logic [EW-1:0] exp_i,
  input  logic          sign_i,
  input  logic          guard_i,
  input  logic          round_i,
  input  logic          sticky_i,
  input  logic [1:0]    rmode_i,
  output logic [SW-1:0] add_a_o,
  output logic [SW-1:0] add_b_o,
  output logic          add_load_o,
  input  logic [SW-1:0] add_sum_i,
  input  logic          add_carry_i,
  output logic [SW-1:0] mant_o,
  output logic [EW-1:0] exp_o,
  output logic          ovf_o,
  output logic          inexact_o,
  output logic          done_o
);

  localparam logic [SW-1:0] ADD_ONE  = SW'(1);
  localparam logic [EW-1:0] EXP_MAX  = '1;

  localparam logic [1:0] RM_RNE  = 2'b00;
  localparam logic [1:0] RM_RTZ  = 2'b01;
  localparam logic [1:0] RM_PINF = 2'b10;
  localparam logic [1:0] RM_NINF = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECIDE = 3'd1,
    ADD    = 3'd2,
    CHECK  = 3'd3,
    NORM   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Captured request; everything the later states need, so the input
  // bus is free to change once the request has been accepted.
  typedef struct packed {
    logic [SW-1:0] mant;
    logic [EW-1:0] exp;
    logic          sign;
    logic          g;
    logic          r;
    logic          s;
`ifdef ROUND_MODES_EN
    logic [1:0]    rmode;
`endif
  } req_t;

  state_t        state;
  req_t          req;
  logic          inx;
  logic          inc;
  logic [EW-1:0] exp_inc;

  assign ready_o = (state == IDLE);
  // Operand A always shows the captured mantissa; only B and the strobe
  // are qualified by the ADD state.
  assign add_a_o = req.mant;
  assign inx     = req.g | req.r | req.s;
  assign exp_inc = req.exp + EW'(1);

  // Increment decision from the captured request.
  always_comb begin
    inc = req.g & (req.r | req.s | req.mant[0]);
`ifdef ROUND_MODES_EN
    case (req.rmode)
      RM_RNE:  inc = req.g & (req.r | req.s | req.mant[0]);
      RM_RTZ:  inc = 1'b0;
      RM_PINF: inc = ~req.sign & inx;
      RM_NINF: inc =  req.sign & inx;
      default: inc = 1'b0;
    endcase
`endif
  end

`ifndef ROUND_MODES_EN
  // Round mode is not used in this build; mode constants and the port are
  // kept so both builds share one interface.
  logic unused_rmode;
  assign unused_rmode = ^{rmode_i, RM_RNE, RM_RTZ, RM_PINF, RM_NINF};
`endif

  // Single sequencer. Strobes (done_o, add_load_o, add_b_o) are registered
  // and set on the edge entering the state in which they must be high, so
  // they line up exactly with ADD / DONE and reset clears them asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req        <= '0;
      mant_o     <= '0;
      exp_o      <= '0;
      ovf_o      <= 1'b0;
      inexact_o  <= 1'b0;
      done_o     <= 1'b0;
      add_load_o <= 1'b0;
      add_b_o    <= '0;
    end else begin
      done_o     <= 1'b0;
      add_load_o <= 1'b0;
      add_b_o    <= '0;
      case (state)
        IDLE: begin
          if (start_i) begin
            req.mant  <= mant_i;
            req.exp   <= exp_i;
            req.sign  <= sign_i;
            req.g     <= guard_i;
            req.r     <= round_i;
            req.s     <= sticky_i;
`ifdef ROUND_MODES_EN
            req.rmode <= rmode_i;
`endif
            state     <= DECIDE;
          end
        end
        DECIDE: begin
          inexact_o <= inx;
          if (inc) begin
            add_load_o <= 1'b1;
            add_b_o    <= ADD_ONE;
            state      <= ADD;
          end else begin
            mant_o <= req.mant;
            exp_o  <= req.exp;
            ovf_o  <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        ADD: begin
          // Adder result/carry registers load on this edge.
          state <= CHECK;
        end
        CHECK: begin
          if (!add_carry_i) begin
            mant_o <= add_sum_i;
            exp_o  <= req.exp;
            ovf_o  <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            state <= NORM;
          end
        end
        NORM: begin
          // Carry out means the sum is 1.000..0 one bit above the mantissa;
          // shift right by one and bump the exponent.
          mant_o <= {1'b1, add_sum_i[SW-1:1]};
          exp_o  <= exp_inc;
          ovf_o  <= (exp_inc == EXP_MAX);
          done_o <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_add_ctrl.sv
module tb_round_add_ctrl;

  localparam int SW = 26;
  localparam int EW = 8;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic          ready_o;
  logic [SW-1:0] mant_i;
  logic [EW-1:0] exp_i;
  logic          sign_i;
  logic          guard_i;
  logic          round_i;
  logic          sticky_i;
  logic [1:0]    rmode_i;
  logic [SW-1:0] add_a_o;
  logic [SW-1:0] add_b_o;
  logic          add_load_o;
  logic [SW-1:0] add_sum;
  logic          add_carry;
  logic [SW-1:0] mant_o;
  logic [EW-1:0] exp_o;
  logic          ovf_o;
  logic          inexact_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  round_add_ctrl #(.SW(SW), .EW(EW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .ready_o    (ready_o),
    .mant_i     (mant_i),
    .exp_i      (exp_i),
    .sign_i     (sign_i),
    .guard_i    (guard_i),
    .round_i    (round_i),
    .sticky_i   (sticky_i),
    .rmode_i    (rmode_i),
    .add_a_o    (add_a_o),
    .add_b_o    (add_b_o),
    .add_load_o (add_load_o),
    .add_sum_i  (add_sum),
    .add_carry_i(add_carry),
    .mant_o     (mant_o),
    .exp_o      (exp_o),
    .ovf_o      (ovf_o),
    .inexact_o  (inexact_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered round adder: result and carry load one edge after the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {add_carry, add_sum} <= '0;
    else if (add_load_o) {add_carry, add_sum} <= {1'b0, add_a_o} + {1'b0, add_b_o};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle numbering: cycle 0 ends on the start-accept edge; cycle k is
  // sampled 1 time unit after edge k-1.
  int done_cyc, load_cyc, load_cnt;
  logic [SW-1:0] b_at_load;

  task automatic do_req(input logic [SW-1:0] m, input logic [EW-1:0] e,
                        input logic s, input logic g, input logic r,
                        input logic st, input logic [1:0] rm);
    for (int w = 0; w < 10 && !ready_o; w++) begin
      @(posedge clk); #1;
    end
    mant_i = m; exp_i = e; sign_i = s;
    guard_i = g; round_i = r; sticky_i = st; rmode_i = rm;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    done_cyc = -1; load_cyc = -1; load_cnt = 0; b_at_load = '0;
    for (int c = 1; c <= 10; c++) begin
      if (add_load_o) begin
        load_cnt++;
        load_cyc = c;
        b_at_load = add_b_o;
      end
      if (done_o) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  int dcount;

  initial begin
    rst = 1'b0; start_i = 1'b0; mant_i = '0; exp_i = '0; sign_i = 1'b0;
    guard_i = 1'b0; round_i = 1'b0; sticky_i = 1'b0; rmode_i = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_load", 32'(add_load_o), 32'd0);
    chk("rst_mant", 32'(mant_o), 32'd0);
    chk("rst_exp_ovf_inx", 32'({exp_o, ovf_o, inexact_o}), 32'd0);
    chk("rst_ab", 32'(add_a_o | add_b_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: RNE tie to even, no increment
    do_req(26'h0000004, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("t1_done_cyc", 32'(done_cyc), 32'd2);
    chk("t1_loads", 32'(load_cnt), 32'd0);
    chk("t1_mant", 32'(mant_o), 32'h0000004);
    chk("t1_exp", 32'(exp_o), 32'h40);
    chk("t1_inexact", 32'(inexact_o), 32'd1);

    // 2: RNE tie to even, increment without carry
    do_req(26'h0000005, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("t2_done_cyc", 32'(done_cyc), 32'd4);
    chk("t2_load_cyc", 32'(load_cyc), 32'd2);
    chk("t2_loads", 32'(load_cnt), 32'd1);
    chk("t2_b", 32'(b_at_load), 32'd1);
    chk("t2_mant", 32'(mant_o), 32'h0000006);
    chk("t2_ovf", 32'(ovf_o), 32'd0);

    // Exact input: nothing below the LSB, no increment, not inexact
    do_req(26'h0000007, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("ex_done_cyc", 32'(done_cyc), 32'd2);
    chk("ex_mant", 32'(mant_o), 32'h0000007);
    chk("ex_inexact", 32'(inexact_o), 32'd0);

    // Below half (g=0) with odd mantissa: RNE keeps it
    do_req(26'h0000009, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    chk("lo_mant", 32'(mant_o), 32'h0000009);
    chk("lo_inexact", 32'(inexact_o), 32'd1);

    // 3: increment with carry -> renormalise
    do_req(26'h3FFFFFF, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    chk("t3_done_cyc", 32'(done_cyc), 32'd5);
    chk("t3_mant", 32'(mant_o), 32'h2000000);
    chk("t3_exp", 32'(exp_o), 32'h11);
    chk("t3_ovf", 32'(ovf_o), 32'd0);

    // 4: renormalise into the all-ones exponent
    do_req(26'h3FFFFFF, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    chk("t4_done_cyc", 32'(done_cyc), 32'd5);
    chk("t4_mant", 32'(mant_o), 32'h2000000);
    chk("t4_exp", 32'(exp_o), 32'hFF);
    chk("t4_ovf", 32'(ovf_o), 32'd1);

`ifdef ROUND_MODES_EN
    do_req(26'h3FFFFFF, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
    chk("t4_rtz_done_cyc", 32'(done_cyc), 32'd2);
    chk("t4_rtz_mant", 32'(mant_o), 32'h3FFFFFF);
    chk("t4_rtz_exp", 32'(exp_o), 32'hFE);
    chk("t4_rtz_ovf", 32'(ovf_o), 32'd0);

    // 5: directed modes on a negative value
    do_req(26'h0000010, 8'h30, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
    chk("t5_ninf_mant", 32'(mant_o), 32'h0000011);
    chk("t5_ninf_done_cyc", 32'(done_cyc), 32'd4);
    do_req(26'h0000010, 8'h30, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
    chk("t5_pinf_mant", 32'(mant_o), 32'h0000010);
    chk("t5_pinf_done_cyc", 32'(done_cyc), 32'd2);
`else
    // Mode input ignored: RTZ request still rounds to nearest even
    do_req(26'h3FFFFFF, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
    chk("t4_nomode_mant", 32'(mant_o), 32'h2000000);
    chk("t4_nomode_ovf", 32'(ovf_o), 32'd1);
    do_req(26'h0000010, 8'h30, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
    chk("t5_nomode_mant", 32'(mant_o), 32'h0000010);
    chk("t5_nomode_done_cyc", 32'(done_cyc), 32'd2);
`endif
    chk("t5_inexact", 32'(inexact_o), 32'd1);

    // 5b: second start while busy is ignored; one done per accepted request
    for (int w = 0; w < 10 && !ready_o; w++) begin
      @(posedge clk); #1;
    end
    mant_i = 26'h0000005; exp_i = 8'h40; sign_i = 1'b0;
    guard_i = 1'b1; round_i = 1'b0; sticky_i = 1'b0; rmode_i = 2'b00;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_ready", 32'(ready_o), 32'd0);
    @(posedge clk); #1;
    mant_i = 26'h0000100; guard_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    dcount = 0;
    for (int c = 0; c < 10; c++) begin
      if (done_o) dcount++;
      @(posedge clk); #1;
    end
    chk("busy_done_count", 32'(dcount), 32'd1);
    chk("busy_mant", 32'(mant_o), 32'h0000006);
    chk("busy_idle", 32'(ready_o), 32'd1);

    // 6: reset during ADD aborts immediately
    mant_i = 26'h0000005; exp_i = 8'h40; guard_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("t6_in_add", 32'(add_load_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_load_drop", 32'(add_load_o), 32'd0);
    chk("t6_ready", 32'(ready_o), 32'd1);
    chk("t6_b_zero", 32'(add_b_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    dcount = 0;
    for (int c = 0; c < 6; c++) begin
      if (done_o) dcount++;
      @(posedge clk); #1;
    end
    chk("t6_no_done", 32'(dcount), 32'd0);
    do_req(26'h0000005, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("t6_after_done_cyc", 32'(done_cyc), 32'd4);
    chk("t6_after_mant", 32'(mant_o), 32'h0000006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_add_ctrl.md
Name: round_add_ctrl

Overview:
Sequencer for the multiplier's rounding stage. Accepts a normalised mantissa with exponent, sign and guard/round/sticky bits, and decides whether to increment. When an increment is needed it drives the registered round adder (SW-bit adder plus result and carry registers, one-cycle load latency). It then inspects the adder carry, renormalises on mantissa overflow and returns the rounded mantissa and exponent with a done pulse.

Parameters:
SW, 26, mantissa/adder width in bits; must match the round adder width
EW, 8, exponent width in bits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
start_i  in  1  request; accepted only when ready_o=1
ready_o  out  1  controller idle, can accept start_i
mant_i  in  SW  mantissa to round
exp_i  in  EW  biased exponent
sign_i  in  1  result sign
guard_i, round_i, sticky_i  in  1 each  rounding bits below mantissa LSB
rmode_i  in  2  00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
add_a_o  out  SW  adder operand A
add_b_o  out  SW  adder operand B
add_load_o  out  1  load strobe to adder result/carry registers
add_sum_i  in  SW  registered adder sum
add_carry_i  in  1  registered adder carry-out
mant_o  out  SW  rounded mantissa
exp_o  out  EW  adjusted exponent
ovf_o  out  1  exponent reached all-ones after renormalisation
inexact_o  out  1  guard|round|sticky of the accepted request
done_o  out  1  one-cycle pulse, results valid

Behaviour:
- Reset (rst=0, async): state IDLE; mant_o, exp_o, ovf_o, inexact_o, done_o, add_load_o, add_a_o, add_b_o all 0; ready_o=1. Asserting reset mid-operation aborts immediately; add_load_o drops without waiting for a clock; no done_o is issued for the aborted request.
- ready_o=1 only in IDLE. start_i in any other state is ignored; no queueing.
- IDLE: on start_i=1, register mant_i, exp_i, sign_i, g/r/s and rmode_i, then go to DECIDE.
- DECIDE: x = g|r|s; inexact_o<=x. inc = RNE: g&(r|s|mant[0]); RTZ: 0; +inf: ~sign&x; -inf: sign&x.
  - inc=1: go to ADD.
  - inc=0: mant_o<=mant_r, exp_o<=exp_r, ovf_o<=0, go to DONE.
- ADD: add_a_o=mant_r, add_b_o=1 (zero-extended), add_load_o=1 for exactly this cycle; go to CHECK. Outside ADD, add_a_o=mant_r, add_b_o=0 and add_load_o=0.
- CHECK: adder registers are valid.
  - add_carry_i=0: mant_o<=add_sum_i, exp_o<=exp_r, ovf_o<=0, go to DONE.
  - add_carry_i=1: go to NORM.
- NORM: mant_o<={1'b1, add_sum_i[SW-1:1]}; exp_o<=exp_r+1 (modulo 2^EW); ovf_o<=1 if exp_r+1 equals all-ones; go to DONE.
- DONE: done_o=1 for one cycle, then go to IDLE. mant_o, exp_o, ovf_o and inexact_o hold until the next request's DECIDE/CHECK/NORM update.
- Latency, counting the start-accept edge as cycle 0, done_o is high in:
  - cycle 2 with no increment;
  - cycle 4 with an increment and no carry;
  - cycle 5 with an increment and a carry.
- An exp_i of all-ones is outside the legal input range; the result is unspecified except that no hang occurs.

Optional Feature:
ROUND_MODES_EN. Defined: rmode_i honoured as above. Undefined: rmode_i ignored, RNE always used, and rmode_i is neither registered nor compared.

Test Plan:
1. SW=26/EW=8, RNE, mant=0x0000004, g=1 r=0 s=0 -> no add_load_o pulse; done_o in cycle 2; mant_o=0x0000004, inexact_o=1.
2. RNE, mant=0x0000005, g=1 r=0 s=0 -> add_load_o high only in cycle 2, add_b_o=1; done_o in cycle 4; mant_o=0x0000006.
3. RNE, mant=0x3FFFFFF, exp=0x10, g=1 s=1 -> carry=1; done_o in cycle 5; mant_o=0x2000000, exp_o=0x11, ovf_o=0.
4. RNE, mant=0x3FFFFFF, exp=0xFE, g=1 r=1 -> exp_o=0xFF, ovf_o=1. Then RTZ with the same inputs -> mant_o=0x3FFFFFF, exp_o=0xFE, ovf_o=0, done_o in cycle 2.
5. ROUND_MODES_EN defined, mant=0x10, sign=1, g=0 r=0 s=1: rmode=11 -> 0x11; rmode=10 -> 0x10. Macro undefined, rmode=11 -> 0x10. A second start_i while busy is ignored, one done_o per accepted request.
6. Pull rst low during ADD -> add_load_o=0 and ready_o=1 immediately, no done_o. After release, a new request per test 2 completes normally.
